// File: rtl/dram_pkg.sv
// Shared DRAM AXI ID remapper types: board ID widths, counter sizing, AXI structs.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dram_pkg;

    // MIG ID width per board
    localparam int unsigned DdrIdWidthDdr4 = 4;
    localparam int unsigned DdrIdWidthDdr3 = 6;
    localparam int unsigned DdrIdWidth     = DdrIdWidthDdr4;

    // Outstanding transactions allowed on a single DDR ID slot
    localparam int unsigned MaxTxnsPerId = 8;
    localparam int unsigned CntWidth     = $clog2(MaxTxnsPerId + 1);

    typedef logic [DdrIdWidth-1:0] slot_idx_t;
    typedef logic [CntWidth-1:0]   cnt_t;

    // SoC-side AXI geometry
    localparam int unsigned SocIdWidth = 8;
    localparam int unsigned AddrWidth  = 32;
    localparam int unsigned DataWidth  = 64;

    typedef logic [SocIdWidth-1:0] soc_id_t;

    typedef struct packed {
        soc_id_t               id;
        logic [AddrWidth-1:0]  addr;
        logic [7:0]            len;
        logic [2:0]            size;
        logic [1:0]            burst;
        logic                  user;
    } ax_chan_t;

    typedef struct packed {
        logic [DataWidth-1:0]   data;
        logic [DataWidth/8-1:0] strb;
        logic                   last;
        logic                   user;
    } w_chan_t;

    typedef struct packed {
        soc_id_t    id;
        logic [1:0] resp;
        logic       user;
    } b_chan_t;

    typedef struct packed {
        soc_id_t              id;
        logic [DataWidth-1:0] data;
        logic [1:0]           resp;
        logic                 last;
        logic                 user;
    } r_chan_t;

    typedef struct packed {
        ax_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ax_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } axi_req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        b_chan_t b;
        logic    b_valid;
        r_chan_t r;
        logic    r_valid;
    } axi_resp_t;

endpackage

// File: rtl/dram_id_remap_table.sv
// One direction of outstanding-ID tracking: maps a SoC ID to a DDR slot and back.
// Latency: zero-cycle grant/slot lookup; table updates visible the cycle after a push/pop.
// Backpressure: grant drops when no slot fits; the chosen slot is locked while valid is stalled.
module dram_id_remap_table #(
    parameter int unsigned IdWidth   = dram_pkg::SocIdWidth,
    parameter int unsigned SlotWidth = dram_pkg::DdrIdWidth,
    parameter int unsigned MaxTxns   = dram_pkg::MaxTxnsPerId
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IdWidth-1:0]   req_id,
    input  logic                 req_valid,
    input  logic                 req_ready,
    input  logic [SlotWidth-1:0] rsp_slot,
    input  logic                 rsp_pop,
    output logic                 grant,
    output logic [SlotWidth-1:0] slot,
    output logic [IdWidth-1:0]   restored_id
);

    localparam int NumSlots = 2 ** SlotWidth;
    localparam int unsigned CntWidth = $clog2(MaxTxns + 1);
    localparam logic [CntWidth-1:0] CntMax = CntWidth'(MaxTxns);

    logic [IdWidth-1:0]   soc_id_q [NumSlots];
    logic [CntWidth-1:0]  cnt_q    [NumSlots];
    logic                 lock_vld_q;
    logic [SlotWidth-1:0] lock_slot_q;

    logic                 match_found;
    logic [SlotWidth-1:0] match_idx;
    logic                 free_found;
    logic [SlotWidth-1:0] free_idx;
    logic                 push;
    logic [NumSlots-1:0]  inc;
    logic [NumSlots-1:0]  dec;

    // Find the slot already holding this SoC ID and the lowest-index free slot.
    always_comb begin
        match_found = 1'b0;
        match_idx   = '0;
        free_found  = 1'b0;
        free_idx    = '0;
        for (int i = 0; i < NumSlots; i++) begin
            if (!match_found && cnt_q[i] != '0 && soc_id_q[i] == req_id) begin
                match_found = 1'b1;
                match_idx   = SlotWidth'(i);
            end
            if (!free_found && cnt_q[i] == '0) begin
                free_found = 1'b1;
                free_idx   = SlotWidth'(i);
            end
        end
    end

    // Lock wins, then the ordering-preserving match, then a fresh slot.
    always_comb begin
        slot  = free_idx;
        grant = 1'b0;
        if (lock_vld_q) begin
            slot  = lock_slot_q;
            grant = 1'b1;
        end else if (match_found) begin
            slot  = match_idx;
            grant = cnt_q[match_idx] < CntMax;
        end else if (free_found) begin
            slot  = free_idx;
            grant = cnt_q[free_idx] < CntMax;
        end
    end

    assign push        = req_valid & req_ready & grant;
    assign restored_id = soc_id_q[rsp_slot];

    // Per-slot increment/decrement; a pop on an idle slot is ignored so the count never wraps.
    always_comb begin
        inc = '0;
        dec = '0;
        for (int i = 0; i < NumSlots; i++) begin
            inc[i] = push && (slot == SlotWidth'(i));
            dec[i] = rsp_pop && (rsp_slot == SlotWidth'(i)) && (cnt_q[i] != '0);
        end
    end

    // Table state: SoC ID written on every push, counter tracks outstanding responses.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NumSlots; i++) begin
                soc_id_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < NumSlots; i++) begin
                if (inc[i]) begin
                    soc_id_q[i] <= req_id;
                end
                if (inc[i] && !dec[i]) begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end else if (dec[i] && !inc[i]) begin
                    cnt_q[i] <= cnt_q[i] - 1'b1;
                end
            end
        end
    end

    // Hold the offered slot while the downstream stalls so the outgoing ID stays stable.
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_vld_q  <= 1'b0;
            lock_slot_q <= '0;
        end else if (req_valid && grant && req_ready) begin
            lock_vld_q <= 1'b0;
        end else if (req_valid && grant && !req_ready) begin
            lock_vld_q  <= 1'b1;
            lock_slot_q <= slot;
        end
    end

    // A response for a slot with nothing outstanding means the MIG broke protocol.
    always_ff @(posedge clk) begin
        if (!rst && rsp_pop) begin
            assert (cnt_q[rsp_slot] != '0)
            else $error("response on idle DDR ID slot %0d", rsp_slot);
        end
    end

endmodule

// File: rtl/dram_axi_id_remapper.sv
// Compresses SoC AXI IDs onto the MIG's narrow ID space and restores them on B/R.
// Latency: zero cycles on every channel; only the valid/ready gating depends on table state.
// Backpressure: AW/AR are held off (valid and ready both low) until a slot has capacity.
module dram_axi_id_remapper #(
    parameter type         axi_req_t    = dram_pkg::axi_req_t,
    parameter type         axi_resp_t   = dram_pkg::axi_resp_t,
    parameter int unsigned DdrIdWidth   = dram_pkg::DdrIdWidth,
    parameter int unsigned MaxTxnsPerId = dram_pkg::MaxTxnsPerId
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  axi_req_t  slv_req_i,
    output axi_resp_t slv_rsp_o,
    output axi_req_t  mst_req_o,
    input  axi_resp_t mst_rsp_i
);

    localparam int unsigned SocIdWidth = $bits(slv_req_i.aw.id);

    logic                  aw_grant;
    logic                  ar_grant;
    logic [DdrIdWidth-1:0] aw_slot;
    logic [DdrIdWidth-1:0] ar_slot;
    logic [SocIdWidth-1:0] b_soc_id;
    logic [SocIdWidth-1:0] r_soc_id;
    logic                  b_pop;
    logic                  r_pop;

    // A write completes on its B; a read completes only on its last R beat.
    assign b_pop = mst_rsp_i.b_valid & slv_req_i.b_ready;
    assign r_pop = mst_rsp_i.r_valid & slv_req_i.r_ready & mst_rsp_i.r.last;

    dram_id_remap_table #(
        .IdWidth   (SocIdWidth),
        .SlotWidth (DdrIdWidth),
        .MaxTxns   (MaxTxnsPerId)
    ) u_wr_table (
        .clk         (clk_i),
        .rst         (rst_i),
        .req_id      (slv_req_i.aw.id),
        .req_valid   (slv_req_i.aw_valid),
        .req_ready   (mst_rsp_i.aw_ready),
        .rsp_slot    (mst_rsp_i.b.id[DdrIdWidth-1:0]),
        .rsp_pop     (b_pop),
        .grant       (aw_grant),
        .slot        (aw_slot),
        .restored_id (b_soc_id)
    );

    dram_id_remap_table #(
        .IdWidth   (SocIdWidth),
        .SlotWidth (DdrIdWidth),
        .MaxTxns   (MaxTxnsPerId)
    ) u_rd_table (
        .clk         (clk_i),
        .rst         (rst_i),
        .req_id      (slv_req_i.ar.id),
        .req_valid   (slv_req_i.ar_valid),
        .req_ready   (mst_rsp_i.ar_ready),
        .rsp_slot    (mst_rsp_i.r.id[DdrIdWidth-1:0]),
        .rsp_pop     (r_pop),
        .grant       (ar_grant),
        .slot        (ar_slot),
        .restored_id (r_soc_id)
    );

    // Toward the MIG: pass everything, swap in slot IDs and gate address valids.
    always_comb begin
        mst_req_o          = slv_req_i;
        mst_req_o.aw.id    = SocIdWidth'(aw_slot);
        mst_req_o.aw_valid = slv_req_i.aw_valid & aw_grant;
        mst_req_o.ar.id    = SocIdWidth'(ar_slot);
        mst_req_o.ar_valid = slv_req_i.ar_valid & ar_grant;
    end

    // Toward the SoC: pass everything, restore SoC IDs, gate address readies.
    always_comb begin
        slv_rsp_o          = mst_rsp_i;
        slv_rsp_o.aw_ready = mst_rsp_i.aw_ready & aw_grant;
        slv_rsp_o.ar_ready = mst_rsp_i.ar_ready & ar_grant;
        slv_rsp_o.b.id     = b_soc_id;
        slv_rsp_o.b.user   = 1'b0;
        slv_rsp_o.r.id     = r_soc_id;
        slv_rsp_o.r.user   = 1'b0;
    end

endmodule
